// File: rtl/ram_write.sv
`default_nettype none
// ============================================================================
// Module   : ram_write
// Purpose  : Insertion side of the 16-slot object table held in the shared
//            32 x 8 coordinate RAM. On go, scans slots 0..15 for the first
//            free slot (x byte == 0) and writes the (x, y) pair into it.
//            Optional macro RAM_WRITE_CLEAR_EN adds a post-reset CLEAR pass
//            that zeroes all 32 RAM bytes before the block goes idle.
// Revision : 1.0 - initial release
// ============================================================================
module ram_write (
    input  logic       clk,
    input  logic       reset,
    input  logic       go,
    input  logic [7:0] x_in,
    input  logic [6:0] y_in,
    input  logic [7:0] data_in,
    output logic [4:0] address,
    output logic [7:0] data_out,
    output logic       writeEn,
    output logic       busy,
    output logic       done,
    output logic       full,
    output logic       reject,
    output logic [3:0] slot
);

    localparam logic [3:0] c_ST_IDLE    = 4'd0;
    localparam logic [3:0] c_ST_LOAD    = 4'd1;
    localparam logic [3:0] c_ST_READ    = 4'd2;
    localparam logic [3:0] c_ST_WAIT    = 4'd3;
    localparam logic [3:0] c_ST_CHECK   = 4'd4;
    localparam logic [3:0] c_ST_WRITE_X = 4'd5;
    localparam logic [3:0] c_ST_WRITE_Y = 4'd6;
    localparam logic [3:0] c_ST_DONE    = 4'd7;
    localparam logic [3:0] c_ST_FULL    = 4'd8;
    localparam logic [3:0] c_ST_REJECT  = 4'd9;
    localparam logic [3:0] c_ST_CLEAR   = 4'd10;

`ifdef RAM_WRITE_CLEAR_EN
    localparam logic [3:0] c_ST_RESET   = c_ST_CLEAR;
`else
    localparam logic [3:0] c_ST_RESET   = c_ST_IDLE;
`endif

    localparam logic [3:0] c_LAST_SLOT  = 4'd15;

    logic [3:0] r_state;
    logic [3:0] w_state_nxt;
    logic [7:0] r_x;
    logic [6:0] r_y;
    logic [3:0] r_ptr;
    logic [3:0] r_slot;

`ifdef RAM_WRITE_CLEAR_EN
    logic [4:0] r_clr_addr;

    // Clear-pass address counter: walks 0..31 while in CLEAR.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_clr_addr <= 5'd0;
        end else if (r_state == c_ST_CLEAR) begin
            r_clr_addr <= r_clr_addr + 5'd1;
        end
    end
`endif

    // State register plus the datapath registers advanced per state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_ST_RESET;
            r_x     <= 8'd0;
            r_y     <= 7'd0;
            r_ptr   <= 4'd0;
            r_slot  <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                c_ST_LOAD: begin
                    r_x   <= x_in;
                    r_y   <= y_in;
                    r_ptr <= 4'd0;
                end
                c_ST_CHECK: begin
                    // Advance only past an occupied, non-final slot; the
                    // pointer never wraps so the scan stops at slot 15.
                    if ((data_in != 8'd0) && (r_ptr != c_LAST_SLOT)) begin
                        r_ptr <= r_ptr + 4'd1;
                    end
                end
                c_ST_WRITE_Y: begin
                    r_slot <= r_ptr;
                end
                default: begin
                end
            endcase
        end
    end

    // Next-state logic and output decode from the registered state only.
    always_comb begin
        w_state_nxt = r_state;
        address     = {r_ptr, 1'b0};
        data_out    = 8'd0;
        writeEn     = 1'b0;
        busy        = (r_state != c_ST_IDLE);
        done        = 1'b0;
        full        = 1'b0;
        reject      = 1'b0;

        case (r_state)
            c_ST_IDLE: begin
                if (go) begin
                    w_state_nxt = c_ST_LOAD;
                end
            end
            c_ST_LOAD: begin
                w_state_nxt = (x_in == 8'd0) ? c_ST_REJECT : c_ST_READ;
            end
            c_ST_READ: begin
                w_state_nxt = c_ST_WAIT;
            end
            c_ST_WAIT: begin
                // Address held an extra cycle to cover the RAM read latency.
                w_state_nxt = c_ST_CHECK;
            end
            c_ST_CHECK: begin
                if (data_in == 8'd0) begin
                    w_state_nxt = c_ST_WRITE_X;
                end else if (r_ptr == c_LAST_SLOT) begin
                    w_state_nxt = c_ST_FULL;
                end else begin
                    w_state_nxt = c_ST_READ;
                end
            end
            c_ST_WRITE_X: begin
                address     = {r_ptr, 1'b0};
                data_out    = r_x;
                writeEn     = 1'b1;
                w_state_nxt = c_ST_WRITE_Y;
            end
            c_ST_WRITE_Y: begin
                address     = {r_ptr, 1'b1};
                data_out    = {1'b0, r_y};
                writeEn     = 1'b1;
                w_state_nxt = c_ST_DONE;
            end
            c_ST_DONE: begin
                done        = 1'b1;
                w_state_nxt = c_ST_IDLE;
            end
            c_ST_FULL: begin
                full        = 1'b1;
                w_state_nxt = c_ST_IDLE;
            end
            c_ST_REJECT: begin
                reject      = 1'b1;
                w_state_nxt = c_ST_IDLE;
            end
`ifdef RAM_WRITE_CLEAR_EN
            c_ST_CLEAR: begin
                address  = r_clr_addr;
                data_out = 8'd0;
                writeEn  = 1'b1;
                if (r_clr_addr == 5'd31) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
`endif
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    assign slot = r_slot;

endmodule
`default_nettype wire

// File: tb/tb_ram_write.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_write
// Purpose  : Directed self-checking bench for ram_write with a behavioural
//            synchronous-read RAM model (1-cycle read latency).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram_write;

    logic       clk = 1'b0;
    logic       reset;
    logic       go;
    logic [7:0] x_in;
    logic [6:0] y_in;
    logic [7:0] data_in;
    logic [4:0] address;
    logic [7:0] data_out;
    logic       writeEn;
    logic       busy;
    logic       done;
    logic       full;
    logic       reject;
    logic [3:0] slot;

    int total = 0;
    int bad   = 0;

    // RAM model
    logic [7:0] mem [32];
    logic [7:0] img [32];
    logic       ld = 1'b0;

    // Operation log filled by run_op
    int         nw;
    int         w_cyc  [64];
    logic [4:0] w_addr [64];
    logic [7:0] w_data [64];
    int         done_c, full_c, rej_c, idle_c;

    ram_write dut (
        .clk      (clk),
        .reset    (reset),
        .go       (go),
        .x_in     (x_in),
        .y_in     (y_in),
        .data_in  (data_in),
        .address  (address),
        .data_out (data_out),
        .writeEn  (writeEn),
        .busy     (busy),
        .done     (done),
        .full     (full),
        .reject   (reject),
        .slot     (slot)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ld) begin
            mem <= img;
        end else if (writeEn) begin
            mem[address] <= data_out;
        end
        data_in <= mem[address];
    end

    task automatic load_img();
        @(negedge clk);
        ld = 1'b1;
        @(negedge clk);
        ld = 1'b0;
        @(negedge clk);
    endtask

    task automatic clear_img();
        for (int i = 0; i < 32; i++) img[i] = 8'd0;
    endtask

    // Pulses go (cycle 0) and logs activity per cycle until busy drops.
    task automatic run_op(input logic [7:0] x, input logic [6:0] y, input int maxc);
        nw = 0; done_c = -1; full_c = -1; rej_c = -1; idle_c = -1;
        @(negedge clk);
        x_in = x; y_in = y; go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        for (int c = 1; c <= maxc; c++) begin
            if (c > 1) @(negedge clk);
            if (c == 2) begin
                x_in = ~x;
                y_in = ~y;
            end
            if (writeEn && nw < 64) begin
                w_cyc[nw] = c; w_addr[nw] = address; w_data[nw] = data_out; nw++;
            end
            if (done   && done_c < 0) done_c = c;
            if (full   && full_c < 0) full_c = c;
            if (reject && rej_c  < 0) rej_c  = c;
            if (!busy) begin
                idle_c = c;
                break;
            end
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; go = 1'b0; x_in = 8'd0; y_in = 7'd0;
        repeat (3) @(negedge clk);
        total++;
        if ({address, data_out, writeEn, done, full, reject, slot} !== 23'd0) begin
            bad++;
            $display("FAIL reset_outputs: got %h expected 0",
                     {address, data_out, writeEn, done, full, reject, slot});
        end
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_busy: got %b expected 0", busy);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_empty();
        clear_img();
        load_img();
        run_op(8'd40, 7'd25, 20);
        chk("empty_nwrites", nw, 2);
        chk("empty_wx_cycle", w_cyc[0], 5);
        chk("empty_wx_addr", int'(w_addr[0]), 0);
        chk("empty_wx_data", int'(w_data[0]), 40);
        chk("empty_wy_cycle", w_cyc[1], 6);
        chk("empty_wy_addr", int'(w_addr[1]), 1);
        chk("empty_wy_data", int'(w_data[1]), 25);
        chk("empty_done_cycle", done_c, 7);
        chk("empty_idle_cycle", idle_c, 8);
        chk("empty_slot", int'(slot), 0);
    endtask

    task automatic test_three_used();
        clear_img();
        img[0] = 8'd1; img[1] = 8'd11;
        img[2] = 8'd2; img[3] = 8'd12;
        img[4] = 8'd3; img[5] = 8'd13;
        load_img();
        run_op(8'd99, 7'd10, 30);
        chk("three_nwrites", nw, 2);
        chk("three_wx_cycle", w_cyc[0], 14);
        chk("three_wx_addr", int'(w_addr[0]), 6);
        chk("three_wy_addr", int'(w_addr[1]), 7);
        chk("three_wy_data", int'(w_data[1]), 10);
        chk("three_done_cycle", done_c, 16);
        chk("three_slot", int'(slot), 3);
        chk("three_mem_x", int'(mem[6]), 99);
        chk("three_mem_y", int'(mem[7]), 10);
    endtask

    task automatic test_full();
        for (int i = 0; i < 32; i++) img[i] = 8'(i + 1);
        load_img();
        run_op(8'd77, 7'd5, 70);
        chk("full_nwrites", nw, 0);
        chk("full_cycle", full_c, 50);
        chk("full_no_done", done_c, -1);
        chk("full_idle_cycle", idle_c, 51);
        chk("full_slot_kept", int'(slot), 3);
    endtask

    task automatic test_reject();
        clear_img();
        load_img();
        run_op(8'd0, 7'd9, 20);
        chk("reject_cycle", rej_c, 2);
        chk("reject_nwrites", nw, 0);
        chk("reject_idle_cycle", idle_c, 3);
        chk("reject_slot_kept", int'(slot), 3);
    endtask

    task automatic test_slot15();
        for (int i = 0; i < 32; i++) img[i] = 8'(i + 1);
        img[30] = 8'd0;
        load_img();
        run_op(8'd200, 7'd100, 70);
        chk("s15_nwrites", nw, 2);
        chk("s15_wx_cycle", w_cyc[0], 50);
        chk("s15_wx_addr", int'(w_addr[0]), 30);
        chk("s15_wy_addr", int'(w_addr[1]), 31);
        chk("s15_wy_data", int'(w_data[1]), 100);
        chk("s15_done_cycle", done_c, 52);
        chk("s15_slot", int'(slot), 15);
    endtask

    task automatic test_reset_mid();
        int ndone;
        clear_img();
        load_img();
        @(negedge clk);
        x_in = 8'd7; y_in = 7'd8; go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        repeat (5) @(negedge clk);
        chk("rmid_in_write_y", int'({writeEn, address}), int'({1'b1, 5'd1}));
        reset = 1'b1;
        @(negedge clk);
        chk("rmid_busy", int'(busy), 0);
        chk("rmid_writeEn", int'(writeEn), 0);
        chk("rmid_done", int'(done), 0);
        chk("rmid_slot", int'(slot), 0);
        reset = 1'b0;
        ndone = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done || writeEn) ndone++;
        end
        chk("rmid_no_later_activity", ndone, 0);
    endtask

    task automatic test_back_to_back();
        int nd;
        int d_cyc [4];
        int d_slot[4];
        clear_img();
        load_img();
        nw = 0; nd = 0;
        @(negedge clk);
        x_in = 8'd5; y_in = 7'd6; go = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (writeEn && nw < 64) begin
                w_addr[nw] = address; w_data[nw] = data_out; nw++;
            end
            if (done && nd < 4) begin
                d_cyc[nd] = c; d_slot[nd] = int'(slot); nd++;
            end
            if (c == 32) go = 1'b0;
        end
        chk("b2b_ndone", nd, 3);
        chk("b2b_nwrites", nw, 6);
        chk("b2b_done0", d_cyc[0], 7);
        chk("b2b_done1", d_cyc[1], 18);
        chk("b2b_done2", d_cyc[2], 32);
        chk("b2b_slot1", d_slot[1], 1);
        chk("b2b_slot2", d_slot[2], 2);
        for (int i = 0; i < 6; i++) begin
            chk("b2b_waddr", int'(w_addr[i]), i);
            chk("b2b_wdata", int'(w_data[i]), (i % 2 == 0) ? 5 : 6);
        end
        chk("b2b_idle", int'(busy), 0);
    endtask

    initial begin
        reset = 1'b1; go = 1'b0; x_in = 8'd0; y_in = 7'd0;
        test_reset();
        test_empty();
        test_three_used();
        test_full();
        test_reject();
        test_slot15();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
